// File: rtl/gpu_host_cmd_ctrl.sv
// Host command/launch controller: AXI-lite register port, kernel-launch registers, round-robin CTA dispatch.
// Define GPU_HOST_PERF_EN to build the KCYCLES busy-cycle counter at 0x1C.
module gpu_host_cmd_ctrl #(
  parameter int NUM_SMS    = 4,
  parameter int ADDR_WIDTH = 40,
  parameter int GRID_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  host_awvalid,
  output logic                  host_awready,
  input  logic [31:0]           host_awaddr,
  input  logic                  host_wvalid,
  output logic                  host_wready,
  input  logic [31:0]           host_wdata,
  output logic                  host_bvalid,
  input  logic                  host_bready,
  input  logic                  host_arvalid,
  output logic                  host_arready,
  input  logic [31:0]           host_araddr,
  output logic                  host_rvalid,
  input  logic                  host_rready,
  output logic [31:0]           host_rdata,
  output logic [NUM_SMS-1:0]    launch_valid,
  input  logic [NUM_SMS-1:0]    launch_ready,
  output logic [GRID_W-1:0]     launch_cta_id,
  output logic [ADDR_WIDTH-1:0] launch_pc,
  input  logic [NUM_SMS-1:0]    sm_done,
  output logic                  irq
);

  localparam int PTR_W   = (NUM_SMS > 1) ? $clog2(NUM_SMS) : 1;
  localparam int PC_HI_W = ADDR_WIDTH - 32;
  localparam int CNT_W   = $clog2(NUM_SMS + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPATCH = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;

  logic [1:0]            state_reg;
  logic [PTR_W-1:0]      ptr_reg;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [GRID_W-1:0]     grid_reg;
  logic [GRID_W-1:0]     issued_reg;
  logic [GRID_W-1:0]     completed_reg;
  logic                  done_reg;
  logic                  irq_en_reg;
  logic                  irq_reg;
  logic                  bvalid_reg;
  logic                  rvalid_reg;
  logic [31:0]           rdata_reg;

  logic        wr_acc;
  logic        rd_acc;
  logic [29:0] wr_word;
  logic [29:0] rd_word;
  logic        busy;
  logic        start;
  logic        dispatching;
  logic        fire;
  logic        last_issue;
  logic        done_set;
  logic        done_clr;
  logic [NUM_SMS-1:0] offer;
  logic [PTR_W-1:0]   ptr_next;
  logic [CNT_W-1:0]   done_cnt;
  logic [GRID_W:0]    comp_sum;
  logic [GRID_W-1:0]  comp_next;
  logic [31:0]        rd_mux;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{host_awaddr[1:0], host_araddr[1:0]};

  // Address and data beats are only taken together, and only once the previous response has drained.
  assign wr_acc       = host_awvalid & host_wvalid & ~bvalid_reg;
  assign host_awready = wr_acc;
  assign host_wready  = wr_acc;
  assign host_bvalid  = bvalid_reg;
  assign rd_acc       = host_arvalid & ~rvalid_reg;
  assign host_arready = ~rvalid_reg;
  assign host_rvalid  = rvalid_reg;
  assign host_rdata   = rdata_reg;
  assign irq          = irq_reg;

  assign wr_word     = host_awaddr[31:2];
  assign rd_word     = host_araddr[31:2];
  assign busy        = (state_reg != ST_IDLE);
  assign dispatching = (state_reg == ST_DISPATCH);
  assign start       = wr_acc && (wr_word == 30'd0) && host_wdata[0] && !busy;

  generate
    for (genvar gi = 0; gi < NUM_SMS; gi++) begin : g_offer
      assign offer[gi] = dispatching && (ptr_reg == PTR_W'(gi));
    end
  endgenerate

  assign launch_valid  = offer;
  assign launch_cta_id = dispatching ? issued_reg : '0;
  assign launch_pc     = dispatching ? pc_reg : '0;
  assign fire          = |(offer & launch_ready);
  assign last_issue    = fire && ((issued_reg + GRID_W'(1)) == grid_reg);
  assign ptr_next      = (ptr_reg == PTR_W'(NUM_SMS - 1)) ? '0 : ptr_reg + PTR_W'(1);

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_SMS; i++) begin
      done_cnt = done_cnt + CNT_W'(sm_done[i]);
    end
  end

  assign comp_sum  = {1'b0, completed_reg} + (GRID_W + 1)'(done_cnt);
  assign comp_next = (comp_sum > {1'b0, grid_reg}) ? grid_reg : comp_sum[GRID_W-1:0];

  assign done_set = (start && (grid_reg == '0)) ||
                    ((state_reg == ST_DRAIN) && (completed_reg == grid_reg));
  assign done_clr = (wr_acc && (wr_word == 30'd1) && host_wdata[1]) ||
                    (start && (grid_reg != '0));

`ifdef GPU_HOST_PERF_EN
  logic [31:0] kcycles_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kcycles_reg <= '0;
    end else if (start) begin
      kcycles_reg <= '0;
    end else if (busy && (kcycles_reg != 32'hFFFF_FFFF)) begin
      kcycles_reg <= kcycles_reg + 32'd1;
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (rd_word)
      30'd0:   rd_mux = {30'd0, irq_en_reg, 1'b0};
      30'd1:   rd_mux = {30'd0, done_reg, busy};
      30'd2:   rd_mux = pc_reg[31:0];
      30'd3:   rd_mux = 32'(pc_reg[ADDR_WIDTH-1:32]);
      30'd4:   rd_mux = 32'(grid_reg);
      30'd5:   rd_mux = 32'(issued_reg);
      30'd6:   rd_mux = 32'(completed_reg);
`ifdef GPU_HOST_PERF_EN
      30'd7:   rd_mux = kcycles_reg;
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      pc_reg        <= '0;
      grid_reg      <= '0;
      issued_reg    <= '0;
      completed_reg <= '0;
      done_reg      <= 1'b0;
      irq_en_reg    <= 1'b0;
      irq_reg       <= 1'b0;
      bvalid_reg    <= 1'b0;
      rvalid_reg    <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      if (bvalid_reg && host_bready) begin
        bvalid_reg <= 1'b0;
      end else if (wr_acc) begin
        bvalid_reg <= 1'b1;
      end

      // rdata is sampled from current state, so a same-cycle write is not visible.
      if (rd_acc) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_mux;
      end else if (rvalid_reg && host_rready) begin
        rvalid_reg <= 1'b0;
      end

      if (wr_acc && (wr_word == 30'd0)) irq_en_reg <= host_wdata[1];
      if (wr_acc && (wr_word == 30'd2) && !busy) pc_reg[31:0] <= host_wdata;
      if (wr_acc && (wr_word == 30'd3) && !busy) pc_reg[ADDR_WIDTH-1:32] <= host_wdata[PC_HI_W-1:0];
      if (wr_acc && (wr_word == 30'd4) && !busy) grid_reg <= host_wdata[GRID_W-1:0];

      if (done_set) begin
        done_reg <= 1'b1;
      end else if (done_clr) begin
        done_reg <= 1'b0;
      end
      irq_reg <= done_reg & irq_en_reg;

      case (state_reg)
        ST_IDLE: begin
          if (start && (grid_reg != '0)) begin
            state_reg     <= ST_DISPATCH;
            issued_reg    <= '0;
            completed_reg <= '0;
            ptr_reg       <= '0;
          end
        end
        ST_DISPATCH: begin
          completed_reg <= comp_next;
          if (fire) begin
            issued_reg <= issued_reg + GRID_W'(1);
            ptr_reg    <= ptr_next;
          end
          if (last_issue) state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          completed_reg <= comp_next;
          if (completed_reg == grid_reg) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_host_cmd_ctrl.sv
// Self-checking bench for gpu_host_cmd_ctrl: register vector table, read/launch scoreboards,
// hand-written sequences for stalls, same-cycle read/write, async reset and empty-grid start.
`timescale 1ns/1ps
module tb_gpu_host_cmd_ctrl;
  localparam int NUM_SMS    = 4;
  localparam int ADDR_WIDTH = 40;
  localparam int GRID_W     = 16;
  localparam logic [ADDR_WIDTH-1:0] KPC = 40'h02_0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic host_awvalid = 0, host_wvalid = 0, host_bready = 1, host_arvalid = 0, host_rready = 1;
  logic [31:0] host_awaddr = '0, host_wdata = '0, host_araddr = '0;
  logic host_awready, host_wready, host_bvalid, host_arready, host_rvalid, irq;
  logic [31:0] host_rdata;
  logic [NUM_SMS-1:0] launch_valid;
  logic [NUM_SMS-1:0] launch_ready = '0;
  logic [NUM_SMS-1:0] sm_done = '0;
  logic [GRID_W-1:0] launch_cta_id;
  logic [ADDR_WIDTH-1:0] launch_pc;

  always #5 clk = ~clk;

  gpu_host_cmd_ctrl #(.NUM_SMS(NUM_SMS), .ADDR_WIDTH(ADDR_WIDTH), .GRID_W(GRID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_awvalid(host_awvalid), .host_awready(host_awready), .host_awaddr(host_awaddr),
    .host_wvalid(host_wvalid), .host_wready(host_wready), .host_wdata(host_wdata),
    .host_bvalid(host_bvalid), .host_bready(host_bready),
    .host_arvalid(host_arvalid), .host_arready(host_arready), .host_araddr(host_araddr),
    .host_rvalid(host_rvalid), .host_rready(host_rready), .host_rdata(host_rdata),
    .launch_valid(launch_valid), .launch_ready(launch_ready), .launch_cta_id(launch_cta_id),
    .launch_pc(launch_pc), .sm_done(sm_done), .irq(irq)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int lv_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    int                    sm;
    logic [GRID_W-1:0]     cta;
    logic [ADDR_WIDTH-1:0] pc;
  } launch_t;
  launch_t launch_q[$];
  logic [31:0] rd_q[$];

  // Launch scoreboard: a handshake about to happen on the next edge pops one expected CTA.
  always @(negedge clk) begin : launch_mon
    launch_t e;
    int sm;
    #2;
    if (rst_n && launch_valid != '0) lv_seen++;
    if (rst_n && (launch_valid & launch_ready) != '0) begin
      sm = -1;
      for (int i = 0; i < NUM_SMS; i++) if (launch_valid[i]) sm = i;
      if (launch_q.size() == 0) begin
        check("launch_unexpected", 64'(launch_valid), 64'd0);
      end else begin
        e = launch_q.pop_front();
        check("launch_onehot", 64'($countones(launch_valid)), 64'd1);
        check("launch_sm", 64'(sm), 64'(e.sm));
        check("launch_cta", 64'(launch_cta_id), 64'(e.cta));
        check("launch_pc", 64'(launch_pc), 64'(e.pc));
        $display("launch cta=%0d sm=%0d pc=0x%0h", launch_cta_id, sm, launch_pc);
      end
    end
  end

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, output int acc_cyc);
    int n;
    @(negedge clk);
    host_awvalid = 1; host_wvalid = 1; host_awaddr = addr; host_wdata = data;
    #1;
    n = 0;
    while (!host_awready && n < 20) begin @(negedge clk); #1; n++; end
    if (!host_awready) check("wr_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    host_awvalid = 0; host_wvalid = 0;
    n = 0;
    while (!host_bvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!host_bvalid) check("wr_bvalid_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    $display("wr addr=0x%02h data=0x%08h", addr, data);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    int n;
    logic [31:0] e;
    rd_q.push_back(exp);
    @(negedge clk);
    host_arvalid = 1; host_araddr = addr;
    #1;
    n = 0;
    while (!host_arready && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    host_arvalid = 0;
    n = 0;
    while (!host_rvalid && n < 20) begin @(posedge clk); #1; n++; end
    e = rd_q.pop_front();
    if (!host_rvalid) check({name, "_timeout"}, 64'd0, 64'd1);
    else check(name, 64'(host_rdata), 64'(e));
    $display("rd addr=0x%02h data=0x%08h", addr, host_rdata);
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [NUM_SMS-1:0] m);
    @(negedge clk); sm_done = m;
    @(posedge clk); #1; sm_done = '0;
    $display("sm_done pulse 0x%0h", m);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    string       name;
  } vec_t;
  vec_t tbl[28];

  task automatic apply(input int lo, input int hi);
    int s;
    for (int i = lo; i <= hi; i++) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data, s);
      else rd_chk(tbl[i].name, tbl[i].addr, tbl[i].data);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s_cyc, e_cyc, tmp, n;
    logic [31:0] exp;
    tbl[0]  = '{0, 32'h00, 32'h0, "rst_ctrl"};
    tbl[1]  = '{0, 32'h04, 32'h0, "rst_status"};
    tbl[2]  = '{0, 32'h08, 32'h0, "rst_pc_lo"};
    tbl[3]  = '{0, 32'h0C, 32'h0, "rst_pc_hi"};
    tbl[4]  = '{0, 32'h10, 32'h0, "rst_grid"};
    tbl[5]  = '{0, 32'h14, 32'h0, "rst_issued"};
    tbl[6]  = '{0, 32'h18, 32'h0, "rst_completed"};
    tbl[7]  = '{0, 32'h1C, 32'h0, "rst_kcycles"};
    tbl[8]  = '{0, 32'h40, 32'h0, "rst_unmapped"};
    tbl[9]  = '{1, 32'h08, 32'h0000_1000, "w_pc_lo"};
    tbl[10] = '{1, 32'h0D, 32'h2, "w_pc_hi"};
    tbl[11] = '{1, 32'h10, 32'h6, "w_grid"};
    tbl[12] = '{1, 32'h44, 32'hFFFF_FFFF, "w_unmapped"};
    tbl[13] = '{0, 32'h0B, 32'h0000_1000, "pc_lo"};
    tbl[14] = '{0, 32'h0C, 32'h2, "pc_hi"};
    tbl[15] = '{0, 32'h10, 32'h6, "grid"};
    tbl[16] = '{0, 32'h44, 32'h0, "unmapped_wr_dropped"};
    tbl[17] = '{1, 32'h0C, 32'hFFFF_FFFF, "w_pc_hi_all"};
    tbl[18] = '{0, 32'h0C, 32'hFF, "pc_hi_width"};
    tbl[19] = '{1, 32'h0C, 32'h2, "w_pc_hi"};
    tbl[20] = '{1, 32'h10, 32'h0001_2345, "w_grid_wide"};
    tbl[21] = '{0, 32'h10, 32'h2345, "grid_width"};
    tbl[22] = '{1, 32'h10, 32'h6, "w_grid"};
    tbl[23] = '{1, 32'h00, 32'h2, "w_irq_en"};
    tbl[24] = '{0, 32'h00, 32'h2, "ctrl_irq_en"};
    tbl[25] = '{0, 32'h04, 32'h0, "status_idle"};
    tbl[26] = '{1, 32'h14, 32'hFFFF, "w_issued_ro"};
    tbl[27] = '{0, 32'h14, 32'h0, "issued_ro"};

    repeat (3) @(negedge clk);
    check("rst_launch_valid0", 64'(launch_valid), 64'd0);
    check("rst_bvalid0", 64'(host_bvalid), 64'd0);
    check("rst_rvalid0", 64'(host_rvalid), 64'd0);
    check("rst_irq0", 64'(irq), 64'd0);
    rst_n = 1;
    apply(0, 27);

    // Kernel 1: six CTAs, all SMs ready
    launch_ready = '1;
    for (int i = 0; i < 6; i++) launch_q.push_back('{i % NUM_SMS, GRID_W'(i), KPC});
    wr(32'h00, 32'h3, s_cyc);
    n = 0;
    while (launch_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("k1_all_issued", 64'(launch_q.size()), 64'd0);
    @(negedge clk); #2;
    check("k1_valid_dropped", 64'(launch_valid), 64'd0);
    rd_chk("k1_status_busy", 32'h04, 32'h1);
    rd_chk("k1_issued", 32'h14, 32'd6);
    rd_chk("k1_completed_drain", 32'h18, 32'd0);
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0110);
    pulse(4'b1000);
    @(negedge clk); sm_done = 4'b0001;
    @(posedge clk); #1; e_cyc = cyc; sm_done = '0;
    @(posedge clk); #1; check("k1_irq_not_yet", 64'(irq), 64'd0);
    @(posedge clk); #1; check("k1_irq_set", 64'(irq), 64'd1);
    rd_chk("k1_status_done", 32'h04, 32'h2);
    rd_chk("k1_completed", 32'h18, 32'd6);
    pulse(4'b1111);
    rd_chk("idle_done_ignored", 32'h18, 32'd6);
`ifdef GPU_HOST_PERF_EN
    rd_chk("k1_kcycles", 32'h1C, 32'(e_cyc - s_cyc + 1));
`else
    rd_chk("k1_kcycles_absent", 32'h1C, 32'h0);
`endif
    wr(32'h04, 32'h2, tmp);
    check("k1_irq_cleared", 64'(irq), 64'd0);
    rd_chk("k1_status_cleared", 32'h04, 32'h0);

    // Kernel 2: SM1 stalls, offer must hold on SM1
    wr(32'h10, 32'h3, tmp);
    launch_ready = 4'b1101;
    for (int i = 0; i < 3; i++) launch_q.push_back('{i, GRID_W'(i), KPC});
    wr(32'h00, 32'h3, s_cyc);
    n = 0;
    do begin @(negedge clk); #2; n++; end while (launch_valid != 4'b0010 && n < 20);
    check("k2_offer_sm1", 64'(launch_valid), 64'b0010);
    repeat (10) begin
      @(negedge clk); #2;
      check("k2_hold_valid", 64'(launch_valid), 64'b0010);
      check("k2_hold_cta", 64'(launch_cta_id), 64'd1);
    end
    @(negedge clk); launch_ready = '1;
    n = 0;
    while (launch_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("k2_all_issued", 64'(launch_q.size()), 64'd0);
    pulse(4'b1111);
    repeat (2) @(posedge clk);
    #1;
    rd_chk("k2_completed_sat", 32'h18, 32'd3);
    rd_chk("k2_status_done", 32'h04, 32'h2);

    // Same-cycle read and write of GRID: read sees the old value
    rd_q.push_back(32'd3);
    @(negedge clk);
    host_awvalid = 1; host_wvalid = 1; host_awaddr = 32'h10; host_wdata = 32'd6;
    host_arvalid = 1; host_araddr = 32'h10;
    #1;
    check("rw_both_ready", 64'({host_awready, host_arready}), 64'b11);
    @(posedge clk); #1;
    host_awvalid = 0; host_wvalid = 0; host_arvalid = 0;
    exp = rd_q.pop_front();
    check("rw_pre_write_value", 64'(host_rdata), 64'(exp));
    @(posedge clk); #1;
    rd_chk("rw_post_write", 32'h10, 32'd6);

    // Kernel 3: nobody ready, stuck in dispatch; writes while busy are dropped
    launch_ready = '0;
    wr(32'h00, 32'h3, s_cyc);
    @(negedge clk); #2;
    check("k3_offer_sm0", 64'(launch_valid), 64'b0001);
    check("k3_offer_cta0", 64'(launch_cta_id), 64'd0);
    wr(32'h10, 32'd9, tmp);
    wr(32'h00, 32'h3, tmp);
    rd_chk("busy_grid_unchanged", 32'h10, 32'd6);
    rd_chk("busy_status", 32'h04, 32'h1);
    rd_chk("busy_issued", 32'h14, 32'd0);
    rd_chk("busy_unmapped", 32'h40, 32'h0);

    // Read response stalled by rready=0
    rd_q.push_back(32'h0000_1000);
    host_rready = 0;
    @(negedge clk); host_arvalid = 1; host_araddr = 32'h08;
    @(posedge clk); #1; host_arvalid = 0;
    exp = rd_q.pop_front();
    repeat (5) begin
      @(negedge clk);
      check("hold_rvalid", 64'(host_rvalid), 64'd1);
      check("hold_rdata", 64'(host_rdata), 64'(exp));
    end
    host_rready = 1;
    @(posedge clk); #1;
    check("hold_released", 64'(host_rvalid), 64'd0);

    // Async reset in the middle of dispatch with both responses pending
    host_bready = 0; host_rready = 0;
    @(negedge clk);
    host_awvalid = 1; host_wvalid = 1; host_awaddr = 32'h44; host_wdata = 32'h0;
    host_arvalid = 1; host_araddr = 32'h00;
    @(posedge clk); #1;
    host_awvalid = 0; host_wvalid = 0; host_arvalid = 0;
    check("pre_rst_bvalid", 64'(host_bvalid), 64'd1);
    check("pre_rst_rvalid", 64'(host_rvalid), 64'd1);
    check("pre_rst_launch", 64'(launch_valid), 64'b0001);
    @(negedge clk); rst_n = 0; #1;
    check("mid_rst_launch_valid", 64'(launch_valid), 64'd0);
    check("mid_rst_bvalid", 64'(host_bvalid), 64'd0);
    check("mid_rst_rvalid", 64'(host_rvalid), 64'd0);
    check("mid_rst_pc", 64'(launch_pc), 64'd0);
    launch_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1; host_bready = 1; host_rready = 1;
    apply(0, 8);

    // START with GRID=0: immediate DONE, no dispatch
    lv_seen = 0;
    wr(32'h00, 32'h1, tmp);
    repeat (5) @(negedge clk);
    #3;
    check("grid0_no_launch", 64'(lv_seen), 64'd0);
    rd_chk("grid0_status_done", 32'h04, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
